// File: rtl/cpu_pkg.sv
// Shared CPU constants and the fetch-stage state encoding.
package cpu_pkg;

  localparam int XLEN = 32;
  localparam logic [XLEN-1:0] RESET_PC = 32'h0000_0000;
  localparam logic [XLEN-1:0] PC_STEP  = 32'd4;
  // addi x0, x0, 0
  localparam logic [XLEN-1:0] NOP      = 32'h0000_0013;

  typedef enum logic [1:0] {
    FETCH   = 2'd0,
    DISCARD = 2'd1,
    HOLD    = 2'd2
  } fetch_state_e;

  function automatic logic [XLEN-1:0] next_pc(input logic [XLEN-1:0] pc);
    return pc + PC_STEP;
  endfunction

endpackage

// File: rtl/fetch_skid_buffer.sv
// One-entry holding register for an instruction that returns while decode is stalled.
module fetch_skid_buffer
  import cpu_pkg::*;
(
  input  logic            clk,
  input  logic            rst_n,
  input  logic            load,
  input  logic            drop,
  input  logic [XLEN-1:0] data_in,
  output logic [XLEN-1:0] data_out,
  output logic            full
);

  logic [XLEN-1:0] data_reg;
  logic            full_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_reg <= NOP;
      full_reg <= 1'b0;
    end else if (load) begin
      data_reg <= data_in;
      full_reg <= 1'b1;
    end else if (drop) begin
      full_reg <= 1'b0;
    end
  end

  assign data_out = data_reg;
  assign full     = full_reg;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage with IF/ID register, redirect and stale-response discard.
// Define FETCH_SKID_BUF_EN to keep an instruction that returns during a stall.
module fetch_unit
  import cpu_pkg::*;
(
  input  logic            clk,
  input  logic            rst_n,
  input  logic            stall,
  input  logic            flush,
  input  logic            branchTakenFlag,
  input  logic [XLEN-1:0] branchTarget,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_valid,
  input  logic [XLEN-1:0] imem_rdata,
  output logic [XLEN-1:0] if_id_instr,
  output logic [XLEN-1:0] if_id_pc,
  output logic            if_id_valid
);

  fetch_state_e    state_reg, state_next;
  logic [XLEN-1:0] pc_reg, pc_next;
  logic [XLEN-1:0] instr_reg, instr_next;
  logic [XLEN-1:0] ipc_reg, ipc_next;
  logic            ivalid_reg, ivalid_next;
  logic            started_reg;
  logic            accept;
  logic            outstanding;
  logic            deliver;
  logic [XLEN-1:0] deliver_word;

`ifdef FETCH_SKID_BUF_EN
  logic            skid_load;
  logic            skid_drop;
  logic [XLEN-1:0] skid_data;
  logic            skid_full;

  fetch_skid_buffer u_skid (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (skid_load),
    .drop     (skid_drop),
    .data_in  (imem_rdata),
    .data_out (skid_data),
    .full     (skid_full)
  );
`endif

  // Requests start only after the first edge out of reset, so nothing issued
  // before reset can be mistaken for a fresh response.
  assign imem_req    = started_reg && (state_reg == FETCH);
  assign imem_addr   = pc_reg;
  assign accept      = imem_req && imem_valid;
  assign outstanding = !imem_valid && (imem_req || (state_reg == DISCARD));

  always_comb begin
    state_next   = state_reg;
    pc_next      = pc_reg;
    instr_next   = instr_reg;
    ipc_next     = ipc_reg;
    ivalid_next  = ivalid_reg;
    deliver      = 1'b0;
    deliver_word = imem_rdata;
`ifdef FETCH_SKID_BUF_EN
    skid_load    = 1'b0;
    skid_drop    = 1'b0;
`endif
    if (branchTakenFlag) begin
      pc_next     = branchTarget;
      ivalid_next = 1'b0;
      state_next  = outstanding ? DISCARD : FETCH;
`ifdef FETCH_SKID_BUF_EN
      skid_drop   = 1'b1;
`endif
    end else begin
      if ((state_reg == DISCARD) && imem_valid) begin
        state_next = FETCH;
      end
      if (flush) begin
        ivalid_next = 1'b0;
      end else if (stall) begin
`ifdef FETCH_SKID_BUF_EN
        if (accept) begin
          skid_load  = 1'b1;
          state_next = HOLD;
        end
`endif
      end else begin
        ivalid_next = 1'b0;
        if (accept) begin
          deliver = 1'b1;
        end
`ifdef FETCH_SKID_BUF_EN
        else if ((state_reg == HOLD) && skid_full) begin
          deliver      = 1'b1;
          deliver_word = skid_data;
          skid_drop    = 1'b1;
          state_next   = FETCH;
        end
`endif
      end
    end
    if (deliver) begin
      instr_next  = deliver_word;
      ipc_next    = pc_reg;
      ivalid_next = 1'b1;
      pc_next     = next_pc(pc_reg);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg   <= FETCH;
      pc_reg      <= RESET_PC;
      instr_reg   <= NOP;
      ipc_reg     <= '0;
      ivalid_reg  <= 1'b0;
      started_reg <= 1'b0;
    end else begin
      state_reg   <= state_next;
      pc_reg      <= pc_next;
      instr_reg   <= instr_next;
      ipc_reg     <= ipc_next;
      ivalid_reg  <= ivalid_next;
      started_reg <= 1'b1;
    end
  end

  assign if_id_instr = instr_reg;
  assign if_id_pc    = ipc_reg;
  assign if_id_valid = ivalid_reg;

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed scenarios then random traffic
// against a memory model and an instruction-level reference model.
module tb_fetch_unit;

`ifdef FETCH_SKID_BUF_EN
  localparam bit SKID = 1'b1;
`else
  localparam bit SKID = 1'b0;
`endif
  localparam logic [31:0] NOP_WORD = 32'h0000_0013;

  logic        clk;
  logic        rst_n;
  logic        stall;
  logic        flush;
  logic        branchTakenFlag;
  logic [31:0] branchTarget;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_valid;
  logic [31:0] imem_rdata;
  logic [31:0] if_id_instr;
  logic [31:0] if_id_pc;
  logic        if_id_valid;

  fetch_unit dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .stall           (stall),
    .flush           (flush),
    .branchTakenFlag (branchTakenFlag),
    .branchTarget    (branchTarget),
    .imem_req        (imem_req),
    .imem_addr       (imem_addr),
    .imem_valid      (imem_valid),
    .imem_rdata      (imem_rdata),
    .if_id_instr     (if_id_instr),
    .if_id_pc        (if_id_pc),
    .if_id_valid     (if_id_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Reference model: what the program counter and decode register should hold.
  logic [31:0] m_pc, m_instr, m_ipc;
  bit          m_v, m_live, m_stale, m_buf_full;

  // Memory model: one request in flight, answered after mem_cnt cycles.
  bit          mem_busy;
  logic [31:0] mem_addr;
  int          mem_cnt;
  int          lat_fixed;

  function automatic logic [31:0] word(input logic [31:0] a);
    return (a >> 2) * 32'h11 + 32'h11;
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_pc = 32'h0; m_instr = NOP_WORD; m_ipc = 32'h0;
    m_v = 1'b0; m_live = 1'b0; m_stale = 1'b0; m_buf_full = 1'b0;
    mem_busy = 1'b0; mem_addr = 32'h0; mem_cnt = 0;
  endtask

  // One clock cycle: starts and ends 1 time unit after a rising edge.
  task automatic step(input logic br, input logic [31:0] tgt, input logic fl, input logic st);
    logic exp_req, v, accept, owed;
    branchTakenFlag = br; branchTarget = tgt; flush = fl; stall = st;
    exp_req = m_live && !m_stale && !m_buf_full;
    if (!mem_busy && imem_req) begin
      mem_busy = 1'b1;
      mem_addr = imem_addr;
      mem_cnt  = (lat_fixed != 0) ? lat_fixed : $urandom_range(1, 3);
    end
    v = mem_busy && (mem_cnt == 1);
    imem_valid = v;
    imem_rdata = v ? word(mem_addr) : $urandom;
    chk("imem_req", 32'(imem_req), 32'(exp_req));
    chk("imem_addr", imem_addr, m_pc);
    if (mem_busy && imem_req) chk("addr_stable", imem_addr, mem_addr);
    accept = exp_req && v;
    owed   = mem_busy && !v;
    @(posedge clk);
    if (br) begin
      m_pc = tgt; m_v = 1'b0; m_buf_full = 1'b0; m_stale = owed;
    end else begin
      if (m_stale && v) m_stale = 1'b0;
      if (fl) begin
        m_v = 1'b0;
      end else if (st) begin
        if (SKID && accept) m_buf_full = 1'b1;
      end else begin
        m_v = 1'b0;
        if (accept || m_buf_full) begin
          m_v = 1'b1; m_ipc = m_pc; m_instr = word(m_pc);
          m_pc = m_pc + 32'd4; m_buf_full = 1'b0;
        end
      end
    end
    m_live = 1'b1;
    if (v) mem_busy = 1'b0;
    else if (mem_busy) mem_cnt--;
    #1;
    chk("if_id_valid", 32'(if_id_valid), 32'(m_v));
    chk("if_id_pc", if_id_pc, m_ipc);
    chk("if_id_instr", if_id_instr, m_instr);
  endtask

  task automatic idle();
    step(1'b0, 32'h0, 1'b0, 1'b0);
  endtask

  task automatic do_reset();
    branchTakenFlag = 1'b0; branchTarget = 32'h0; flush = 1'b0; stall = 1'b0;
    imem_valid = 1'b0; imem_rdata = 32'h0;
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    model_reset();
    chk("rst_req", 32'(imem_req), 32'h0);
    chk("rst_valid", 32'(if_id_valid), 32'h0);
    chk("rst_pc", imem_addr, 32'h0);
    chk("rst_instr", if_id_instr, NOP_WORD);
    chk("rst_ifpc", if_id_pc, 32'h0);
    @(posedge clk);
    @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  initial begin
    logic [31:0] tgt;
    rst_n = 1'b0;
    lat_fixed = 1;
    do_reset();

    // Streaming at one instruction per cycle.
    chk("first_req_low", 32'(imem_req), 32'h0);
    idle();
    idle(); chk("stream_pc0", if_id_pc, 32'h0); chk("stream_i0", if_id_instr, 32'h11);
    idle(); chk("stream_pc4", if_id_pc, 32'h4); chk("stream_i4", if_id_instr, 32'h22);
    idle(); chk("stream_pc8", if_id_pc, 32'h8); chk("stream_i8", if_id_instr, 32'h33);

    // Stall while the word at 0x8 returns.
    step(1'b1, 32'h0, 1'b0, 1'b0);
    idle(); idle();
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 32'h0, 1'b0, 1'b1);
      chk("stall_frozen_pc", if_id_pc, 32'h4);
      chk("stall_frozen_v", 32'(if_id_valid), 32'h1);
    end
    idle();
    chk("stall_rel_pc", if_id_pc, 32'h8);
    chk("stall_rel_instr", if_id_instr, 32'h33);
    chk("stall_rel_v", 32'(if_id_valid), 32'h1);

    // Redirect while 0xC is outstanding.
    lat_fixed = 3;
    idle();
    step(1'b1, 32'h100, 1'b0, 1'b0);
    chk("redir_v", 32'(if_id_valid), 32'h0);
    chk("redir_addr", imem_addr, 32'h100);
    chk("redir_req_off", 32'(imem_req), 32'h0);
    lat_fixed = 1;
    idle();
    chk("redir_drop_v", 32'(if_id_valid), 32'h0);
    idle();
    chk("redir_pc", if_id_pc, 32'h100);
    chk("redir_instr", if_id_instr, word(32'h100));

    // Branch and stall together.
    step(1'b1, 32'h200, 1'b0, 1'b1);
    chk("br_stall_addr", imem_addr, 32'h200);
    chk("br_stall_v", 32'(if_id_valid), 32'h0);
    idle();
    chk("br_stall_pc", if_id_pc, 32'h200);

    // Wrap at the top of the address space.
    step(1'b1, 32'hFFFF_FFFC, 1'b0, 1'b0);
    idle();
    chk("wrap_ifpc", if_id_pc, 32'hFFFF_FFFC);
    chk("wrap_addr", imem_addr, 32'h0);

    // Reset with a request outstanding.
    lat_fixed = 3;
    idle();
    do_reset();
    chk("rel_req_low", 32'(imem_req), 32'h0);
    lat_fixed = 0;
    idle();
    chk("rel_req", 32'(imem_req), 32'h1);
    chk("rel_addr", imem_addr, 32'h0);

    // Random traffic.
    for (int n = 0; n < 1500; n++) begin
      tgt = $urandom & 32'hFFFF_FFFC;
      if ($urandom_range(0, 3) == 0) tgt = 32'hFFFF_FFF0 | ($urandom & 32'hC);
      step($urandom_range(0, 9) == 0, tgt, $urandom_range(0, 9) == 0, $urandom_range(0, 3) == 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
